// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - ROM, redirect and issue-side signals of the instruction fetch unit
interface instr_fetch_unit_if;
   logic        rom_nrd;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output rom_nrd, rom_addr, inst_valid, inst, inst_pc,
      input  rom_data, redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  rom_nrd, rom_addr, inst_valid, inst, inst_pc,
      output rom_data, redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/ROM fetch front end with a small instruction FIFO and redirect flush
module instr_fetch_unit #(
   parameter int          QUEUE_DEPTH = 4,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter int          ROM_BYTES   = 100
) (
   input  logic                clk,
   input  logic                nrst,
   instr_fetch_unit_if.master  bus
);
   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_END   = 1'b1;
   localparam logic [0:0] ST_RESET =
      (({1'b0, RESET_PC} + 33'd4) > 33'(ROM_BYTES)) ? ST_END : ST_FETCH;

   function automatic logic past_end(input logic [31:0] a);
      return ({1'b0, a} + 33'd4) > 33'(ROM_BYTES);
   endfunction

   logic [0:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   mem_inst [QUEUE_DEPTH];
   logic [31:0]   mem_pc   [QUEUE_DEPTH];

   logic [31:0] redirect_tgt;
   logic        fetch_en;
   logic        head_valid;
   logic        pop;

   // Fetch is gated by nrst so the strobe stays inactive throughout reset.
   assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
   assign fetch_en     = nrst && (state_q == ST_FETCH) &&
                         (count_q < CW'(QUEUE_DEPTH)) && !bus.redirect_valid;
   assign head_valid   = (count_q != '0);
   assign pop          = head_valid && bus.inst_ready && !bus.redirect_valid;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.redirect_valid) begin
         state_d  = past_end(redirect_tgt) ? ST_END : ST_FETCH;
         pc_d     = redirect_tgt;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (fetch_en) begin
            pc_d     = pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (past_end(pc_q + 32'd4)) begin
               state_d = ST_END;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(fetch_en) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_RESET;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (fetch_en) begin
         mem_inst[wr_ptr_q] <= bus.rom_data;
         mem_pc[wr_ptr_q]   <= pc_q;
      end
   end

   assign bus.rom_nrd    = !fetch_en;
   assign bus.rom_addr   = pc_q;
   assign bus.inst_valid = head_valid;
   assign bus.inst       = head_valid ? mem_inst[rd_ptr_q] : 32'h0;
   assign bus.inst_pc    = head_valid ? mem_pc[rd_ptr_q]   : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a ROM model
module tb_instr_fetch_unit;
   localparam int QD  = 4;
   localparam int ROM = 100;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   logic clk;
   logic nrst;
   logic [7:0]  rom [ROM];
   logic [31:0] rom_word;

   exp_t        exp_q[$];
   logic [31:0] mpc;
   bit          ended;
   bit          fetch_exp;
   bit          in_reset;
   int          n_cmp;
   int          n_bad;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .QUEUE_DEPTH (QD),
      .RESET_PC    (32'h0),
      .ROM_BYTES   (ROM)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.master)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      int i;
      i = int'(a);
      if (a <= 32'(ROM - 4)) return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
      return 32'hBAD0_BAD0;
   endfunction

   always_comb rom_word = word_at(bus.rom_addr);
   assign bus.rom_data = bus.rom_nrd ? 32'hBAD0_BAD0 : rom_word;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      mpc       = 32'h0;
      ended     = 1'b0;
      fetch_exp = 1'b0;
   endtask

   // One clock of stimulus; the model applies the same cycle's rules after the edge.
   task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.inst_ready     = rdy;
      fetch_exp = !ended && (exp_q.size() < QD) && !rv;
      @(posedge clk);
      if (rv) begin
         exp_q.delete();
         mpc   = {rpc[31:2], 2'b00};
         ended = (longint'(mpc) + 4 > ROM);
      end else if (fetch_exp) begin
         exp_q.push_back('{pc: mpc, word: word_at(mpc)});
         mpc   = mpc + 32'd4;
         ended = (longint'(mpc) + 4 > ROM);
      end
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!in_reset) begin
            chk("rom_nrd", {31'b0, bus.rom_nrd}, {31'b0, !fetch_exp});
            chk("rom_addr", bus.rom_addr, mpc);
            chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() == 0) begin
               chk("inst_empty", bus.inst, 32'h0);
               chk("inst_pc_empty", bus.inst_pc, 32'h0);
            end else begin
               chk("inst", bus.inst, exp_q[0].word);
               chk("inst_pc", bus.inst_pc, exp_q[0].pc);
               if (bus.inst_ready && !bus.redirect_valid) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < ROM; i++) rom[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) rom[i] = 8'(8'h11 * (i / 4 + 1));
      nrst = 1'b0;
      in_reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b0;
      model_reset();

      repeat (2) @(negedge clk);
      #1;
      chk("reset_nrd", {31'b0, bus.rom_nrd}, 32'h1);
      chk("reset_addr", bus.rom_addr, 32'h0);
      chk("reset_valid", {31'b0, bus.inst_valid}, 32'h0);
      chk("reset_inst", bus.inst, 32'h0);
      chk("reset_pc", bus.inst_pc, 32'h0);

      @(negedge clk);
      nrst = 1'b1;
      in_reset = 1'b0;
      step(0, 32'h0, 0);
      #1;
      chk("first_inst", bus.inst, 32'h1111_1111);
      chk("first_pc", bus.inst_pc, 32'h0);

      repeat (3) step(0, 32'h0, 0);
      #1;
      chk("full_nrd", {31'b0, bus.rom_nrd}, 32'h1);
      chk("full_addr", bus.rom_addr, 32'd16);
      step(0, 32'h0, 1);
      #1;
      chk("pop_head", bus.inst, 32'h2222_2222);
      step(0, 32'h0, 0);
      step(0, 32'h0, 1);

      step(1, 32'h0000_000A, 1);
      #1;
      chk("redir_valid", {31'b0, bus.inst_valid}, 32'h0);
      chk("redir_addr", bus.rom_addr, 32'd8);
      step(0, 32'h0, 0);
      #1;
      chk("redir_inst", bus.inst, 32'h3333_3333);
      chk("redir_pc", bus.inst_pc, 32'd8);

      step(1, 32'h0, 1);
      repeat (12) step(0, 32'h0, 1);

      step(1, 32'd92, 1);
      repeat (4) step(0, 32'h0, 1);
      #1;
      chk("end_nrd", {31'b0, bus.rom_nrd}, 32'h1);
      chk("end_addr", bus.rom_addr, 32'd100);
      step(1, 32'h0, 1);
      #1;
      chk("resume_addr", bus.rom_addr, 32'h0);
      repeat (3) step(0, 32'h0, 1);

      repeat (400) begin
         step(($urandom_range(0, 9) == 0), 32'($urandom_range(0, 127)),
              ($urandom_range(0, 9) < 7));
      end

      step(1, 32'h0, 0);
      repeat (2) step(0, 32'h0, 0);
      #2;
      nrst = 1'b0;
      in_reset = 1'b1;
      #1;
      chk("midrst_valid", {31'b0, bus.inst_valid}, 32'h0);
      chk("midrst_nrd", {31'b0, bus.rom_nrd}, 32'h1);
      chk("midrst_addr", bus.rom_addr, 32'h0);
      @(negedge clk);
      model_reset();
      nrst = 1'b1;
      in_reset = 1'b0;
      repeat (40) begin
         step(($urandom_range(0, 9) == 0), 32'($urandom_range(0, 127)),
              ($urandom_range(0, 9) < 7));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end initiator for the instruction ROM. Holds the program counter, drives the ROM's active-low read strobe and byte address, and captures each big-endian 32-bit word returned combinationally. Buffers fetched words with their PCs in a small FIFO that feeds the Tomasulo issue stage. Accepts branch redirects from the back end and flushes the buffer on each one.

## Interface
- `QUEUE_DEPTH`, 4: instruction FIFO entries (power of two, ≥2).
- `RESET_PC`, 32'h0: PC loaded on reset (word-aligned).
- `ROM_BYTES`, 100: ROM size in bytes; fetch stops at the end of the image.
- `clk` in 1: single clock, all state updates on rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `rom_nrd` out 1: ROM read strobe, active-low.
- `rom_addr` out 32: ROM byte address (always the current PC).
- `rom_data` in 32: ROM word, valid combinationally while `rom_nrd`=0; Z otherwise.
- `redirect_valid` in 1: branch/jump redirect request.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored (forced to 0).
- `inst_valid` out 1: FIFO head holds an instruction.
- `inst` out 32: head instruction word.
- `inst_pc` out 32: PC of the head instruction.
- `inst_ready` in 1: issue stage accepts the head this cycle.

## Operation
- State machine with states FETCH and END.
  - FETCH: fetch enabled.
  - END: PC has passed the image. Entered when a push moves the PC so that PC+4 > `ROM_BYTES`, or when a redirect targets such an address. The FIFO still drains in END.
  - `redirect_valid` moves the FSM to FETCH if the target is in range, otherwise to END.
- Fetch condition: state=FETCH && count<`QUEUE_DEPTH` && !`redirect_valid`. While the condition holds, `rom_nrd`=0. At the clock edge, push {PC, `rom_data`} and set PC←PC+4. Otherwise `rom_nrd`=1.
- Full check uses the registered count. A pop in the same cycle does not allow a push while the FIFO is full (no bypass).
- Pop: `inst_valid` && `inst_ready` advances the read pointer. Push and pop in the same cycle leave the count unchanged.
- Redirect has priority over push and pop. The FIFO is emptied (count←0, pointers←0), PC←{`redirect_pc`[31:2],2'b00}, and no push occurs. The head is not consumed, even if `inst_ready`=1.
- When the FIFO is empty, `inst`=0 and `inst_pc`=0.
- PC arithmetic is 32-bit and wraps modulo 2^32. Wrap is unreachable in practice because of the END check.
- `inst_valid`, `inst`, and `inst_pc` are driven from FIFO registers only; there is no combinational path from `rom_data`.
- `rom_nrd` depends combinationally on `redirect_valid`.

## Timing
- Reset values: PC=`RESET_PC`, count=0, state=FETCH (END if `RESET_PC`+4 > `ROM_BYTES`), `rom_nrd`=1 while `nrst`=0, `rom_addr`=`RESET_PC`, `inst_valid`=0, `inst`=0, `inst_pc`=0.
- Reset asserted mid-operation clears state immediately (asynchronous), discarding FIFO contents and the in-flight fetch.
- Fetch-to-issue latency: a word read in cycle N is visible at `inst` with `inst_valid`=1 after rising edge N, i.e. 1 cycle.
- Throughput: 1 instruction/cycle while the FIFO is not full.
- Redirect in cycle N:
  - `inst_valid`=0 after edge N.
  - Target is fetched in cycle N+1.
  - Target is visible after edge N+1.
- Full FIFO: `rom_nrd`=1 until the cycle after a pop drops the count below `QUEUE_DEPTH`.

## Test plan
- **Reset and first fetch:** ROM bytes 00..0F = 11 11 11 11 22 22 22 22 33 33 33 33 44 44 44 44, `inst_ready`=0, release `nrst` → `rom_nrd`=0 and `rom_addr`=0 in the first cycle; after edge 1, `inst_valid`=1, `inst`=32'h11111111, `inst_pc`=0.
- **Fill to full:** same image, `inst_ready`=0 → after 4 edges count=4, `rom_nrd`=1, `rom_addr`=16. Then pulse `inst_ready` for 1 cycle → head becomes 32'h22222222, and the word at 16 is pushed on the following edge.
- **Streaming:** `inst_ready`=1 constantly → `inst_pc` sequence 0,4,8,12,… on consecutive cycles, with no bubbles.
- **Redirect:** redirect with FIFO holding 3 entries, `redirect_valid`=1, `redirect_pc`=32'h0000000A → after the edge, `inst_valid`=0 and `rom_addr`=8; the next edge gives `inst_pc`=8, `inst`=32'h33333333.
- **End of image:** `ROM_BYTES`=100, redirect to 92 → fetches 92 and 96, then state=END with `rom_nrd`=1 held and `rom_addr`=100. Redirect to 0 → fetching resumes.
- **Mid-stream reset:** assert `nrst`=0 asynchronously between edges with a non-empty FIFO → `inst_valid`=0, `rom_nrd`=1, `rom_addr`=`RESET_PC` immediately, before the next edge.
